simple_sequencer: RTL
=====================

# simple_sequencer

Multi-cycle phase controller for the SIMPLE 16-bit processor. It steps each instruction through five phases (fetch, decode, execute, memory, writeback) and decodes the instruction register. It drives the ALU opcode and the register, memory and PC strobes, and owns the S/Z/C/V flag register, updating it from ALU results and using it to resolve conditional branches. It sits between the IR/PC/register file and the ALU and starts and stops on the front-panel exec button.

## Interface
- No parameters. Data width is 16 bits and phase count is 5, both fixed.
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high; highest priority.
- exec  in  1  single-cycle pulse from the debounced button; toggles run/stop.
- ir  in  16  current instruction; valid from P2 through P5.
- alu_s, alu_z, alu_c, alu_v  in  1 each  ALU flag outputs for the current opcode.
- phase  out  5  one-hot: bit0 = P1 … bit4 = P5; all zero when idle.
- running  out  1  high while the sequencer is in P1–P5.
- halted  out  1  set by HLT; cleared by the next exec or by reset.
- alu_opcode  out  4  combinational from ir (see decode).
- flag_s, flag_z, flag_c, flag_v  out  1 each  registered flags.
- ir_we, pc_inc  out  1  asserted together during P1.
- mem_re / mem_we  out  1  asserted during P4 for LD / ST.
- reg_we  out  1  asserted during P5 for writing instructions.
- pc_load  out  1  asserted during P5 for a taken branch.

## Operation
- States: IDLE, P1, P2, P3, P4, P5.
- IDLE -> P1 on an exec pulse. P1->P2->P3->P4->P5 unconditionally, one per cycle.
- From P5: go to P1, unless stop_req is set or the instruction is HLT; then go to IDLE.
- stop_req is set by an exec pulse during P1–P5 and cleared on entering IDLE. The current instruction always completes.
- Decode by ir[15:14]:
  - 11, ALU class: alu_opcode = ir[7:4].
    - Opcode 15 = HLT: no strobes; sets halted on the P5->IDLE transition.
    - Opcodes 0–4, 6, 8–12: reg_we in P5.
    - Opcode 5 (CMP): no reg_we.
    - Opcodes 7, 13, 14: NOP, no strobes, no flag update.
  - 00, LD: alu_opcode = 0; mem_re in P4; reg_we in P5.
  - 01, ST: alu_opcode = 0; mem_we in P4.
  - 10, ir[13:11]:
    - 000 LI: alu_opcode = 6; reg_we in P5.
    - 100 B: alu_opcode = 0; pc_load in P5.
    - 111 Bcond: alu_opcode = 0; cond = ir[10:8]. 000 BE takes on Z; 001 BLT on S^V; 010 BLE on Z|(S^V); 011 BNE on ~Z; other cond values are not taken.
    - Other ir[13:11] values: NOP.
- Outside P3, alu_opcode still follows ir, so datapath timing is the caller's concern.
- Flag update: on the edge leaving P3, latch flag_* <= alu_* for ALU-class opcodes 0–6 and 8–12. LD, ST, LI, branches, NOP and HLT hold the flags.
- Branch conditions use the registered flags, i.e. the results of the last flag-updating instruction, never the live ALU outputs.
- An exec pulse in IDLE while halted clears halted and enters P1 in the same edge.

## Timing
- Reset values: state IDLE, phase 0, running 0, halted 0, all flags 0, stop_req 0. All strobes are 0.
- All strobes are combinational from state and ir, active for exactly one cycle per instruction. They are 0 in IDLE.
- Latency: 5 cycles per instruction. The first P1 is 1 cycle after the exec pulse.
- Flags are visible from the first cycle of P4 of the updating instruction.
- Exec in the same cycle as P5: stop takes effect immediately (P5 -> IDLE).
- Exec in the same cycle as HLT's P5: go to IDLE with halted = 1; stop_req is cleared.
- Reset mid-instruction: IDLE next cycle, no further strobes; the partially executed instruction is abandoned.

## Test plan
- Reset, then exec: phase goes 00001, 00010, 00100, 01000, 10000, 00001…; ir_we and pc_inc are high only in P1; running = 1.
- ADD (ir = 0xC000) with alu_z = 1, alu_c = 1 in P3 -> flag_z = 1 and flag_c = 1 from P4; reg_we pulses in P5.
- CMP (ir[7:4] = 5) with alu_s = 1, alu_v = 0, then BLT (ir = 0xB900) -> no reg_we for CMP; BLT asserts pc_load in P5. Repeat with alu_v = 1 -> no pc_load.
- LD, ST, then LI with flags preset to 1111 -> mem_re in P4 only for LD, mem_we in P4 only for ST; flags stay 1111 throughout.
- HLT (ir = 0xC0F0) -> IDLE after P5 with halted = 1 and running = 0. Next exec -> halted = 0, phase = 00001.
- Exec pulse in P2 -> the instruction finishes P5, then IDLE. Separately, reset asserted in P3 -> IDLE next cycle, flags 0, no reg_we.

Source files
------------

// File: rtl/simple_sequencer_if.sv
// Control bundle between the SIMPLE phase sequencer and the surrounding datapath.
// The sequencer uses the master view; the datapath/front panel uses the slave view.
interface simple_sequencer_if;
  logic        exec;
  logic [15:0] ir;
  logic        alu_s;
  logic        alu_z;
  logic        alu_c;
  logic        alu_v;
  logic [4:0]  phase;
  logic        running;
  logic        halted;
  logic [3:0]  alu_opcode;
  logic        flag_s;
  logic        flag_z;
  logic        flag_c;
  logic        flag_v;
  logic        ir_we;
  logic        pc_inc;
  logic        mem_re;
  logic        mem_we;
  logic        reg_we;
  logic        pc_load;

  modport master (
    input  exec, ir, alu_s, alu_z, alu_c, alu_v,
    output phase, running, halted, alu_opcode,
    output flag_s, flag_z, flag_c, flag_v,
    output ir_we, pc_inc, mem_re, mem_we, reg_we, pc_load
  );

  modport slave (
    output exec, ir, alu_s, alu_z, alu_c, alu_v,
    input  phase, running, halted, alu_opcode,
    input  flag_s, flag_z, flag_c, flag_v,
    input  ir_we, pc_inc, mem_re, mem_we, reg_we, pc_load
  );
endinterface

// File: rtl/simple_sequencer.sv
// Five-phase instruction sequencer for the SIMPLE 16-bit CPU: run/stop control,
// instruction decode, S/Z/C/V flag register and branch resolution.
module simple_sequencer (
  input  logic                 clock,
  input  logic                 reset,
  simple_sequencer_if.master   bus
);
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    P1   = 3'd1,
    P2   = 3'd2,
    P3   = 3'd3,
    P4   = 3'd4,
    P5   = 3'd5
  } state_t;

  state_t      state_r;
  state_t      state_s;
  logic        stop_req_r;
  logic        halted_r;
  logic [3:0]  flags_r;      // {s, z, c, v}
  logic [3:0]  opcode_s;
  logic        reg_wr_s;
  logic        flag_upd_s;
  logic        hlt_s;
  logic        ld_s;
  logic        st_s;
  logic        br_take_s;
  logic        cond_s;
  logic        unused_ir_s;

  assign unused_ir_s = ^bus.ir[3:0];

  // Branch condition from the registered flags, never the live ALU outputs.
  always_comb begin
    cond_s = 1'b0;
    case (bus.ir[10:8])
      3'b000:  cond_s = flags_r[2];
      3'b001:  cond_s = flags_r[3] ^ flags_r[0];
      3'b010:  cond_s = flags_r[2] | (flags_r[3] ^ flags_r[0]);
      3'b011:  cond_s = ~flags_r[2];
      default: cond_s = 1'b0;
    endcase
  end

  // Instruction decode: opcode and per-class strobe enables.
  always_comb begin
    opcode_s   = 4'd0;
    reg_wr_s   = 1'b0;
    flag_upd_s = 1'b0;
    hlt_s      = 1'b0;
    ld_s       = 1'b0;
    st_s       = 1'b0;
    br_take_s  = 1'b0;
    case (bus.ir[15:14])
      2'b11: begin
        opcode_s = bus.ir[7:4];
        case (bus.ir[7:4])
          4'd5:               flag_upd_s = 1'b1;
          4'd7, 4'd13, 4'd14: flag_upd_s = 1'b0;
          4'd15:              hlt_s      = 1'b1;
          default: begin
            reg_wr_s   = 1'b1;
            flag_upd_s = 1'b1;
          end
        endcase
      end
      2'b00: begin
        ld_s     = 1'b1;
        reg_wr_s = 1'b1;
      end
      2'b01:   st_s = 1'b1;
      default: begin
        case (bus.ir[13:11])
          3'b000: begin
            opcode_s = 4'd6;
            reg_wr_s = 1'b1;
          end
          3'b100:  br_take_s = 1'b1;
          3'b111:  br_take_s = cond_s;
          default: br_take_s = 1'b0;
        endcase
      end
    endcase
  end

  // Next-state logic; an exec in P5 or a pending stop or HLT ends the run.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.exec) begin
          state_s = P1;
        end else begin
          state_s = IDLE;
        end
      end
      P1: state_s = P2;
      P2: state_s = P3;
      P3: state_s = P4;
      P4: state_s = P5;
      P5: begin
        if (stop_req_r || bus.exec || hlt_s) begin
          state_s = IDLE;
        end else begin
          state_s = P1;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Phase decode and datapath strobes.
  always_comb begin
    bus.phase   = 5'b00000;
    bus.ir_we   = 1'b0;
    bus.pc_inc  = 1'b0;
    bus.mem_re  = 1'b0;
    bus.mem_we  = 1'b0;
    bus.reg_we  = 1'b0;
    bus.pc_load = 1'b0;
    case (state_r)
      P1: begin
        bus.phase  = 5'b00001;
        bus.ir_we  = 1'b1;
        bus.pc_inc = 1'b1;
      end
      P2: bus.phase = 5'b00010;
      P3: bus.phase = 5'b00100;
      P4: begin
        bus.phase  = 5'b01000;
        bus.mem_re = ld_s;
        bus.mem_we = st_s;
      end
      P5: begin
        bus.phase   = 5'b10000;
        bus.reg_we  = reg_wr_s;
        bus.pc_load = br_take_s;
      end
      default: bus.phase = 5'b00000;
    endcase
  end

  assign bus.running    = (state_r != IDLE);
  assign bus.halted     = halted_r;
  assign bus.alu_opcode = opcode_s;
  assign bus.flag_s     = flags_r[3];
  assign bus.flag_z     = flags_r[2];
  assign bus.flag_c     = flags_r[1];
  assign bus.flag_v     = flags_r[0];

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Stop request and halted status.
  always_ff @(posedge clock) begin
    if (reset) begin
      stop_req_r <= 1'b0;
      halted_r   <= 1'b0;
    end else begin
      if (state_s == IDLE) begin
        stop_req_r <= 1'b0;
      end else if (bus.exec && (state_r != IDLE)) begin
        stop_req_r <= 1'b1;
      end else begin
        stop_req_r <= stop_req_r;
      end
      if ((state_r == IDLE) && bus.exec) begin
        halted_r <= 1'b0;
      end else if ((state_r == P5) && (state_s == IDLE) && hlt_s) begin
        halted_r <= 1'b1;
      end else begin
        halted_r <= halted_r;
      end
    end
  end

  // Flags latch from the ALU on the edge leaving P3.
  always_ff @(posedge clock) begin
    if (reset) begin
      flags_r <= 4'b0000;
    end else if ((state_r == P3) && flag_upd_s) begin
      flags_r <= {bus.alu_s, bus.alu_z, bus.alu_c, bus.alu_v};
    end else begin
      flags_r <= flags_r;
    end
  end
endmodule
